sound_capture_buffer: RTL and testbench

//  Record side of the audio path: pulls stereo samples from the codec read

---
 rtl/sound_capture_buffer.sv | 167 ++++++++++++++++
 tb/tb_sound_capture_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_capture_buffer.sv
// Records stereo codec input samples into on-chip RAM and replays the stored
// clip on the codec output interface, optionally looping.
module sound_capture_buffer #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 24000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_rec,
    input  logic              start_play,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic [ADDR_W-1:0] rec_len,
    output logic              busy
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REC    = 2'd1,
        P_LOAD = 2'd2,
        P_OUT  = 2'd3
    } state_t;

    state_t              state_r, state_next_s;
    logic [ADDR_W-1:0]   wr_addr_r, wr_addr_next_s;
    logic [ADDR_W-1:0]   rd_addr_r, rd_addr_next_s;
    logic [ADDR_W-1:0]   rec_len_r, rec_len_next_s;
    logic                busy_r;
    logic                mem_we_s;
    logic                read_s;
    logic                write_s;
    logic [DATA_W-1:0]   wd_left_r, wd_right_r;
    logic [2*DATA_W-1:0] mem_r [0:DEPTH-1];

    // Next-state, address and handshake strobe decode.
    always_comb begin
        state_next_s   = state_r;
        wr_addr_next_s = wr_addr_r;
        rd_addr_next_s = rd_addr_r;
        rec_len_next_s = rec_len_r;
        mem_we_s       = 1'b0;
        read_s         = 1'b0;
        write_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_rec) begin
                    state_next_s   = REC;
                    wr_addr_next_s = ZERO_A;
                end else if (start_play && (rec_len_r != ZERO_A)) begin
                    state_next_s   = P_LOAD;
                    rd_addr_next_s = ZERO_A;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REC: begin
                read_s   = read_ready;
                mem_we_s = read_ready;
                // A sample accepted in the stop cycle still counts toward rec_len.
                if (read_ready && (wr_addr_r == LAST_A)) begin
                    rec_len_next_s = DEPTH_A;
                    state_next_s   = IDLE;
                end else if (read_ready) begin
                    wr_addr_next_s = wr_addr_r + ONE_A;
                    if (stop) begin
                        rec_len_next_s = wr_addr_r + ONE_A;
                        state_next_s   = IDLE;
                    end else begin
                        state_next_s = REC;
                    end
                end else if (stop) begin
                    rec_len_next_s = wr_addr_r;
                    state_next_s   = IDLE;
                end else begin
                    state_next_s = REC;
                end
            end
            P_LOAD: begin
                if (stop) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = P_OUT;
                end
            end
            P_OUT: begin
                write_s = write_ready;
                if (stop) begin
                    state_next_s = IDLE;
                end else if (write_ready) begin
                    if (rd_addr_r == (rec_len_r - ONE_A)) begin
                        if (loop_en) begin
                            rd_addr_next_s = ZERO_A;
                            state_next_s   = P_LOAD;
                        end else begin
                            state_next_s = IDLE;
                        end
                    end else begin
                        rd_addr_next_s = rd_addr_r + ONE_A;
                        state_next_s   = P_LOAD;
                    end
                end else begin
                    state_next_s = P_OUT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control state, addresses, recorded length and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            wr_addr_r <= ZERO_A;
            rd_addr_r <= ZERO_A;
            rec_len_r <= ZERO_A;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            wr_addr_r <= wr_addr_next_s;
            rd_addr_r <= rd_addr_next_s;
            rec_len_r <= rec_len_next_s;
            busy_r    <= (state_next_s != IDLE);
        end
    end

    // Sample RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_addr_r[MEM_AW-1:0]] <= {readdata_left, readdata_right};
        end
    end

    // RAM read port doubles as the output data register, loaded only in P_LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_left_r  <= '0;
            wd_right_r <= '0;
        end else if (state_r == P_LOAD) begin
            {wd_left_r, wd_right_r} <= mem_r[rd_addr_r[MEM_AW-1:0]];
        end
    end

    assign read            = read_s;
    assign write           = write_s;
    assign writedata_left  = wd_left_r;
    assign writedata_right = wd_right_r;
    assign rec_len         = rec_len_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_sound_capture_buffer.sv
// Directed bench for sound_capture_buffer built with an 8-word sample RAM.
module tb_sound_capture_buffer;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start_rec = 1'b0, start_play = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic              read_ready = 1'b0, write_ready = 1'b0;
    logic [DATA_W-1:0] readdata_left = '0, readdata_right = '0;
    logic              read, write, busy;
    logic [DATA_W-1:0] writedata_left, writedata_right;
    logic [ADDR_W-1:0] rec_len;

    int checks = 0;
    int errors = 0;

    sound_capture_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start_rec(start_rec), .start_play(start_play),
        .stop(stop), .loop_en(loop_en), .read_ready(read_ready),
        .readdata_left(readdata_left), .readdata_right(readdata_right), .read(read),
        .write_ready(write_ready), .write(write), .writedata_left(writedata_left),
        .writedata_right(writedata_right), .rec_len(rec_len), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL reset_read: got %0b want 0", read); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %0b want 0", write); end
        checks++; if (rec_len !== 15'd0) begin errors++; $display("FAIL reset_rec_len: got %0d want 0", rec_len); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (writedata_left !== 24'd0 || writedata_right !== 24'd0) begin
            errors++; $display("FAIL reset_writedata: got %0d/%0d want 0/0", writedata_left, writedata_right);
        end
        reset = 1'b0;
    endtask

    task automatic test_record();
        start_rec = 1'b1;
        tick();
        start_rec = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rec_busy: got %0b want 1", busy); end
        for (int k = 1; k <= 5; k++) begin
            read_ready = 1'b1;
            readdata_left = DATA_W'(k);
            readdata_right = DATA_W'(100 + k);
            #1;
            checks++; if (read !== 1'b1) begin errors++; $display("FAIL rec_read_hi k=%0d: got %0b want 1", k, read); end
            tick();
            read_ready = 1'b0;
            #1;
            checks++; if (read !== 1'b0) begin errors++; $display("FAIL rec_read_lo k=%0d: got %0b want 0", k, read); end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        #1;
        checks++; if (rec_len !== 15'd5) begin errors++; $display("FAIL rec_len_5: got %0d want 5", rec_len); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rec_stop_busy: got %0b want 0", busy); end
    endtask

    task automatic test_play_once();
        int nw;
        int last;
        nw = 0;
        last = 0;
        loop_en = 1'b0;
        write_ready = 1'b1;
        start_play = 1'b1;
        tick();
        start_play = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            #1;
            if (write === 1'b1) begin
                checks++;
                if (writedata_left !== DATA_W'(nw + 1) || writedata_right !== DATA_W'(101 + nw)) begin
                    errors++;
                    $display("FAIL play_data #%0d: got %0d/%0d want %0d/%0d", nw, writedata_left, writedata_right, nw + 1, 101 + nw);
                end
                if (nw > 0) begin
                    checks++;
                    if (cyc - last != 2) begin errors++; $display("FAIL play_spacing #%0d: got %0d want 2", nw, cyc - last); end
                end
                last = cyc;
                nw++;
            end
            tick();
        end
        #1;
        checks++; if (nw != 5) begin errors++; $display("FAIL play_count: got %0d want 5", nw); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL play_end_busy: got %0b want 0", busy); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL play_end_write: got %0b want 0", write); end
        checks++; if (writedata_left !== 24'd5 || writedata_right !== 24'd105) begin
            errors++; $display("FAIL play_hold: got %0d/%0d want 5/105", writedata_left, writedata_right);
        end
    endtask

    task automatic test_play_loop();
        int nw;
        logic w1, w2;
        logic [DATA_W-1:0] prev_l;
        nw = 0;
        w1 = 1'b1;
        w2 = 1'b0;
        prev_l = '0;
        loop_en = 1'b1;
        write_ready = 1'b0;
        start_play = 1'b1;
        tick();
        start_play = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            write_ready = (cyc % 3 == 0);
            #1;
            checks++;
            if (write === 1'b1 && write_ready === 1'b0) begin errors++; $display("FAIL loop_write_no_ready cyc=%0d", cyc); end
            if (cyc > 0) begin
                checks++;
                if (writedata_left !== prev_l && !w2) begin
                    errors++; $display("FAIL loop_stable cyc=%0d: got %0d want %0d", cyc, writedata_left, prev_l);
                end
            end
            if (write === 1'b1) begin
                checks++;
                if (writedata_left !== DATA_W'((nw % 5) + 1) || writedata_right !== DATA_W'((nw % 5) + 101)) begin
                    errors++;
                    $display("FAIL loop_data #%0d: got %0d/%0d want %0d/%0d", nw, writedata_left, writedata_right, (nw % 5) + 1, (nw % 5) + 101);
                end
                nw++;
            end
            w2 = w1;
            w1 = write;
            prev_l = writedata_left;
            if (nw == 12) break;
            tick();
        end
        checks++; if (nw != 12) begin errors++; $display("FAIL loop_timeout: got %0d writes want 12", nw); end
        stop = 1'b1;
        write_ready = 1'b0;
        tick();
        stop = 1'b0;
        write_ready = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_stop_busy: got %0b want 0", busy); end
        checks++; if (write !== 1'b0) begin errors++; $display("FAIL loop_stop_write: got %0b want 0", write); end
        write_ready = 1'b0;
        loop_en = 1'b0;
    endtask

    task automatic test_auto_stop();
        int nr;
        int nw;
        nr = 0;
        nw = 0;
        tick();
        start_rec = 1'b1;
        tick();
        start_rec = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            read_ready = 1'b1;
            readdata_left = DATA_W'(201 + cyc);
            readdata_right = DATA_W'(301 + cyc);
            #1;
            if (read !== 1'b1) break;
            nr++;
            tick();
        end
        checks++; if (nr != 8) begin errors++; $display("FAIL auto_count: got %0d want 8", nr); end
        checks++; if (read !== 1'b0) begin errors++; $display("FAIL auto_9th_read: got %0b want 0", read); end
        checks++; if (rec_len !== 15'd8) begin errors++; $display("FAIL auto_rec_len: got %0d want 8", rec_len); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL auto_busy: got %0b want 0", busy); end
        read_ready = 1'b0;
        write_ready = 1'b1;
        start_play = 1'b1;
        tick();
        start_play = 1'b0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            #1;
            if (write === 1'b1) begin
                checks++;
                if (writedata_left !== DATA_W'(201 + nw) || writedata_right !== DATA_W'(301 + nw)) begin
                    errors++;
                    $display("FAIL auto_play_data #%0d: got %0d/%0d want %0d/%0d", nw, writedata_left, writedata_right, 201 + nw, 301 + nw);
                end
                nw++;
            end
            tick();
        end
        checks++; if (nw != 8) begin errors++; $display("FAIL auto_play_count: got %0d want 8", nw); end
        write_ready = 1'b0;
    endtask

    task automatic test_edge_cases();
        // rec_len is 8 here, so start_play alone would be honoured.
        start_rec = 1'b1;
        start_play = 1'b1;
        tick();
        start_rec = 1'b0;
        start_play = 1'b0;
        read_ready = 1'b1;
        write_ready = 1'b1;
        #1;
        checks++; if (read !== 1'b1 || write !== 1'b0) begin
            errors++; $display("FAIL prio_rec: got read=%0b write=%0b want 1/0", read, write);
        end
        tick();
        tick();
        read_ready = 1'b0;
        start_play = 1'b1;
        tick();
        start_play = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || write !== 1'b0 || read !== 1'b0) begin
            errors++; $display("FAIL rec_ignore_play: got busy=%0b write=%0b read=%0b want 1/0/0", busy, write, read);
        end
        reset = 1'b1;
        read_ready = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || read !== 1'b0) begin
            errors++; $display("FAIL reset_mid_rec: got busy=%0b read=%0b want 0/0", busy, read);
        end
        checks++; if (rec_len !== 15'd0) begin errors++; $display("FAIL reset_mid_rec_len: got %0d want 0", rec_len); end
        read_ready = 1'b0;
        start_play = 1'b1;
        tick();
        start_play = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || write !== 1'b0) begin
            errors++; $display("FAIL play_empty: got busy=%0b write=%0b want 0/0", busy, write);
        end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL play_empty_stay: got %0b want 0", busy); end
        write_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_record();
        test_play_once();
        test_play_loop();
        test_auto_stop();
        test_edge_cases();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
